// File: rtl/pcx2max_mc.sv
// Multi-core PCX capture, round-robin arbitration and stream serialiser for NCORE SPARC cores.
// Define PCX_CHKSUM_EN to append an XOR checksum trailer word to every frame.
module pcx2max_mc #(
  parameter int unsigned NCORE      = 4,
  parameter int unsigned PCX_WIDTH  = 124,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 10
) (
  input  logic                       gclk,
  input  logic                       reset_l,
  input  logic [NCORE*5-1:0]         spc_pcx_req_pq,
  input  logic [NCORE-1:0]           spc_pcx_atom_pq,
  input  logic [NCORE*PCX_WIDTH-1:0] spc_pcx_data_pa,
  output logic [NCORE*5-1:0]         pcx_spc_grant_px,
  output logic                       max_pcx_valid,
  output logic [DATA_W-1:0]          max_pcx_data,
  input  logic                       max_pcx_stall,
  output logic [NCORE-1:0]           ovf_err,
  output logic                       pcx_idle
);

  localparam int unsigned FRAME_W = PCX_WIDTH + 10;
  localparam int unsigned NWORDS  = (FRAME_W + DATA_W - 1) / DATA_W;
`ifdef PCX_CHKSUM_EN
  localparam int unsigned NW_TOT  = NWORDS + 1;
`else
  localparam int unsigned NW_TOT  = NWORDS;
`endif
  localparam int unsigned BUF_W   = NW_TOT * DATA_W;
  localparam int unsigned EW      = PCX_WIDTH + 6;
  localparam int unsigned CW      = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW      = $clog2(NW_TOT + 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [NCORE-1:0] w_avail, w_cap_vld, w_pop, w_fifo_empty;
  logic [EW-1:0]    w_head [NCORE];

  function automatic logic [CW-1:0] f_wrap(input logic [CW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NCORE) s = s - NCORE;
    return CW'(s);
  endfunction

  for (genvar c = 0; c < NCORE; c++) begin : g_core
    logic          r_cap_vld, r_cap_atom, r_ovf;
    logic [4:0]    r_cap_dest;
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [NW-1:0] r_cnt;
    logic [EW-1:0] w_in;
    logic          w_empty, w_full, w_push, w_pop_mem, w_drop, w_wr;

    // Entry layout: {atom, dest, data}
    assign w_in      = {r_cap_atom, r_cap_dest, spc_pcx_data_pa[PCX_WIDTH*c +: PCX_WIDTH]};
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == NW'(FIFO_DEPTH));
    assign w_pop_mem = w_pop[c] & ~w_empty;
    // A capture popped straight out of an empty FIFO bypasses the storage.
    assign w_push    = r_cap_vld & ~(w_pop[c] & w_empty);
    assign w_drop    = w_push & w_full & ~w_pop_mem;
    assign w_wr      = w_push & ~w_drop;

    assign w_head[c]       = w_empty ? w_in : r_mem[r_rptr];
    assign w_avail[c]      = ~w_empty | r_cap_vld;
    assign w_cap_vld[c]    = r_cap_vld;
    assign w_fifo_empty[c] = w_empty;
    assign ovf_err[c]      = r_ovf;

    always_ff @(posedge gclk or negedge reset_l) begin
      if (!reset_l) begin
        r_cap_vld  <= 1'b0;
        r_cap_atom <= 1'b0;
        r_cap_dest <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_cap_vld  <= |spc_pcx_req_pq[5*c +: 5];
        r_cap_dest <= spc_pcx_req_pq[5*c +: 5];
        r_cap_atom <= spc_pcx_atom_pq[c];
        if (w_drop) r_ovf <= 1'b1;
        if (w_wr) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
        if (w_pop_mem) r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        case ({w_wr, w_pop_mem})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: ;
        endcase
      end
    end

    always_ff @(posedge gclk) begin
      if (w_wr) r_mem[r_wptr] <= w_in;
    end
  end

  state_e             r_state;
  logic [CW-1:0]      r_rr, r_cur, r_lock_core, w_sel;
  logic               r_lock, w_sel_vld, w_take, w_xfer, w_last_xfer;
  logic [IW-1:0]      r_idx;
  logic [4:0]         r_cur_dest;
  logic [BUF_W-1:0]   r_buf, w_buf;
  logic [DATA_W-1:0]  r_data;
  logic [NCORE*5-1:0] r_grant;
  logic [EW-1:0]      w_head_sel;
`ifdef PCX_CHKSUM_EN
  logic [DATA_W-1:0]  w_csum;
`endif

  // While locked by an atomic frame only the owning core may be served.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    if (r_lock) begin
      w_sel_vld = w_avail[r_lock_core];
      w_sel     = r_lock_core;
    end else begin
      for (int i = NCORE - 1; i >= 0; i--) begin
        if (w_avail[f_wrap(r_rr, i)]) begin
          w_sel_vld = 1'b1;
          w_sel     = f_wrap(r_rr, i);
        end
      end
    end
  end

  always_comb begin
    w_head_sel = w_head[w_sel];
    w_buf      = '0;
    w_buf[FRAME_W-1:0] = {4'(w_sel), w_head_sel};
`ifdef PCX_CHKSUM_EN
    w_csum = '0;
    for (int k = 0; k < NWORDS; k++) w_csum = w_csum ^ w_buf[k*DATA_W +: DATA_W];
    w_buf[NWORDS*DATA_W +: DATA_W] = w_csum;
`endif
  end

  assign w_xfer      = (r_state == StSend) & ~max_pcx_stall;
  assign w_last_xfer = w_xfer & (r_idx == IW'(NW_TOT - 1));
  assign w_take      = w_sel_vld & ((r_state == StIdle) | w_last_xfer);

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NCORE; c++) begin
      if (w_take && (w_sel == CW'(c))) w_pop[c] = 1'b1;
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_buf       <= '0;
      r_data      <= '0;
      r_grant     <= '0;
      r_rr        <= '0;
      r_cur       <= '0;
      r_cur_dest  <= '0;
      r_lock      <= 1'b0;
      r_lock_core <= '0;
    end else begin
      r_grant <= '0;
      if (w_last_xfer) begin
        for (int c = 0; c < NCORE; c++) begin
          if (r_cur == CW'(c)) r_grant[5*c +: 5] <= r_cur_dest;
        end
      end
      if (w_take) begin
        r_state     <= StSend;
        r_idx       <= '0;
        r_data      <= w_buf[DATA_W-1:0];
        r_buf       <= w_buf >> DATA_W;
        r_cur       <= w_sel;
        r_cur_dest  <= w_head_sel[PCX_WIDTH +: 5];
        r_lock      <= w_head_sel[EW-1];
        r_lock_core <= w_sel;
        r_rr        <= (w_sel == CW'(NCORE - 1)) ? '0 : w_sel + 1'b1;
      end else if (w_last_xfer) begin
        r_state <= StIdle;
      end else if (w_xfer) begin
        r_idx  <= r_idx + 1'b1;
        r_data <= r_buf[DATA_W-1:0];
        r_buf  <= r_buf >> DATA_W;
      end
    end
  end

  assign max_pcx_valid    = (r_state == StSend) & ~max_pcx_stall;
  assign max_pcx_data     = r_data;
  assign pcx_spc_grant_px = r_grant;
  assign pcx_idle         = (&w_fifo_empty) & (r_state == StIdle) & ~(|w_cap_vld) & ~r_lock;

endmodule
